// File: rtl/vehicle_sensor_conditioner.sv
// -----------------------------------------------------------------------------
// vehicle_sensor_conditioner
//
// Front end for the farm-road inductive-loop detector. The raw loop signal is
// asynchronous and bouncy. This block:
//   - synchronizes it through a 2-flop chain
//   - debounces it (DEB_CYCLES consecutive agreeing samples)
//   - stretches presence across short gaps (HOLD_CYCLES)
//   - counts arrivals (saturating at 255)
//   - flags a detector stuck high for STUCK_CYCLES.
// While stuck, presence is forced high so the farm road is still served.
//
// Optional feature macro: SENSOR_CLASSIFY_EN
//   When defined, long_vehicle pulses for one cycle on PRESENT -> HOLD if the
//   presence lasted at least 4*DEB_CYCLES cycles.
//   When undefined, long_vehicle is tied to 0.
//
// Ports:
//   clk           in   system clock, rising edge
//   rst_n         in   synchronous active-low reset
//   loop_raw      in   raw loop detector, asynchronous to clk
//   count_clr     in   synchronous clear of vehicle_count (beats an increment)
//   sensor        out  conditioned presence, to the traffic light controller
//   fault         out  detector stuck-high indication
//   vehicle_count out  8-bit saturating arrival count
//   long_vehicle  out  one-cycle long-vehicle flag (0 unless SENSOR_CLASSIFY_EN)
// -----------------------------------------------------------------------------
module vehicle_sensor_conditioner #(
    parameter int DEB_CYCLES   = 16,
    parameter int HOLD_CYCLES  = 200,
    parameter int STUCK_CYCLES = 50000,
    parameter int CNT_W        = 16
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       loop_raw,
    input  logic       count_clr,
    output logic       sensor,
    output logic       fault,
    output logic [7:0] vehicle_count,
    output logic       long_vehicle
);

    localparam logic [CNT_W-1:0] DEB_LAST   = CNT_W'(DEB_CYCLES - 1);
    localparam logic [CNT_W-1:0] HOLD_LAST  = CNT_W'(HOLD_CYCLES - 1);
    localparam logic [CNT_W-1:0] STUCK_LAST = CNT_W'(STUCK_CYCLES - 1);

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_PRESENT = 2'd1,
        ST_HOLD    = 2'd2,
        ST_FAULT   = 2'd3
    } state_t;

    // ------------------------------------------------------------------
    // Synchronizer: sync_q[0] = s1, sync_q[1] = s2. Only s2 is used.
    // ------------------------------------------------------------------
    logic [1:0] sync_q;
    logic       s2;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            sync_q <= 2'b00;
        end else begin
            sync_q <= {sync_q[0], loop_raw};
        end
    end

    assign s2 = sync_q[1];

    // ------------------------------------------------------------------
    // Debounce: deb follows s2 only after DEB_CYCLES consecutive
    // disagreeing samples. Any agreeing sample restarts the count.
    // ------------------------------------------------------------------
    logic             deb_q, deb_d;
    logic [CNT_W-1:0] deb_cnt_q, deb_cnt_d;
    logic             deb_rise;

    always_comb begin
        deb_d     = deb_q;
        deb_cnt_d = '0;
        deb_rise  = 1'b0;
        if (s2 != deb_q) begin
            if (deb_cnt_q == DEB_LAST) begin
                deb_d    = ~deb_q;
                deb_rise = ~deb_q;
            end else begin
                deb_cnt_d = deb_cnt_q + 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            deb_q     <= 1'b0;
            deb_cnt_q <= '0;
        end else begin
            deb_q     <= deb_d;
            deb_cnt_q <= deb_cnt_d;
        end
    end

    // ------------------------------------------------------------------
    // Arrival counter. An arrival is counted on the edge where deb rises.
    // Clear beats increment; the count saturates at 255.
    // ------------------------------------------------------------------
    logic [7:0] count_q, count_d;

    always_comb begin
        count_d = count_q;
        if (count_clr) begin
            count_d = 8'd0;
        end else if (deb_rise && (count_q != 8'hFF)) begin
            count_d = count_q + 8'd1;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            count_q <= 8'd0;
        end else begin
            count_q <= count_d;
        end
    end

    assign vehicle_count = count_q;

    // ------------------------------------------------------------------
    // Presence FSM.
    // sensor_q and fault_q are written together with state_q, so they
    // always equal (state != IDLE) and (state == FAULT) respectively.
    // ------------------------------------------------------------------
    state_t           state_q;
    logic [CNT_W-1:0] hold_cnt_q;
    logic [CNT_W-1:0] stuck_cnt_q;
    logic             sensor_q;
    logic             fault_q;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q     <= ST_IDLE;
            hold_cnt_q  <= '0;
            stuck_cnt_q <= '0;
            sensor_q    <= 1'b0;
            fault_q     <= 1'b0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    stuck_cnt_q <= '0;
                    if (deb_q) begin
                        state_q  <= ST_PRESENT;
                        sensor_q <= 1'b1;
                    end
                end
                ST_PRESENT: begin
                    // A falling deb wins over the stuck limit on the same edge.
                    if (!deb_q) begin
                        state_q     <= ST_HOLD;
                        hold_cnt_q  <= '0;
                        stuck_cnt_q <= '0;
                    end else if (stuck_cnt_q == STUCK_LAST) begin
                        state_q     <= ST_FAULT;
                        fault_q     <= 1'b1;
                        stuck_cnt_q <= '0;
                    end else begin
                        stuck_cnt_q <= stuck_cnt_q + 1'b1;
                    end
                end
                ST_HOLD: begin
                    stuck_cnt_q <= '0;
                    if (deb_q) begin
                        state_q <= ST_PRESENT;
                    end else if (hold_cnt_q == HOLD_LAST) begin
                        state_q  <= ST_IDLE;
                        sensor_q <= 1'b0;
                    end else begin
                        hold_cnt_q <= hold_cnt_q + 1'b1;
                    end
                end
                ST_FAULT: begin
                    stuck_cnt_q <= '0;
                    // Leaving a fault skips the hold extension.
                    if (!deb_q) begin
                        state_q  <= ST_IDLE;
                        sensor_q <= 1'b0;
                        fault_q  <= 1'b0;
                    end
                end
                default: begin
                    state_q     <= ST_IDLE;
                    stuck_cnt_q <= '0;
                    sensor_q    <= 1'b0;
                    fault_q     <= 1'b0;
                end
            endcase
        end
    end

    assign sensor = sensor_q;
    assign fault  = fault_q;

    // ------------------------------------------------------------------
    // Optional long-vehicle classification.
    // ------------------------------------------------------------------
`ifdef SENSOR_CLASSIFY_EN
    localparam int LEN_LIMIT = 4 * DEB_CYCLES;
    localparam int LEN_W     = $clog2(LEN_LIMIT + 1);

    logic [LEN_W-1:0] len_q;
    logic             long_q;

    // len_q holds the cycles already spent in PRESENT. It is zero outside
    // PRESENT, so it starts from zero on every entry. The leaving cycle is
    // counted as part of the presence.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            len_q  <= '0;
            long_q <= 1'b0;
        end else begin
            long_q <= 1'b0;
            if (state_q != ST_PRESENT) begin
                len_q <= '0;
            end else begin
                if (int'(len_q) < LEN_LIMIT) begin
                    len_q <= len_q + 1'b1;
                end
                if (!deb_q) begin
                    long_q <= ((int'(len_q) + 1) >= LEN_LIMIT);
                end
            end
        end
    end

    assign long_vehicle = long_q;
`else
    assign long_vehicle = 1'b0;
`endif

endmodule

// File: tb/tb_vehicle_sensor_conditioner.sv
// -----------------------------------------------------------------------------
// Bench for vehicle_sensor_conditioner with DEB=4, HOLD=8, STUCK=64.
//
// Each stimulus step pushes its expected outputs into a scoreboard queue,
// keyed by the clock-edge number at which they must hold. A monitor runs on
// the falling edge and pops and compares every entry due on that edge.
// -----------------------------------------------------------------------------
module tb_vehicle_sensor_conditioner;

    localparam int DEB   = 4;
    localparam int HOLD  = 8;
    localparam int STUCK = 64;

    localparam int K_SENSOR = 0;
    localparam int K_FAULT  = 1;
    localparam int K_COUNT  = 2;

    logic       clk       = 1'b0;
    logic       rst_n     = 1'b0;
    logic       loop_raw  = 1'b0;
    logic       count_clr = 1'b0;
    logic       sensor;
    logic       fault;
    logic [7:0] vehicle_count;
    logic       long_vehicle;

    int cyc      = 0;
    int n_checks = 0;
    int n_pass   = 0;
    int exp_cnt  = 0;

    typedef struct {
        int    cyc;
        int    kind;
        int    val;
        string tag;
    } exp_t;

    exp_t sb_q[$];

    vehicle_sensor_conditioner #(
        .DEB_CYCLES  (DEB),
        .HOLD_CYCLES (HOLD),
        .STUCK_CYCLES(STUCK),
        .CNT_W       (16)
    ) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .loop_raw     (loop_raw),
        .count_clr    (count_clr),
        .sensor       (sensor),
        .fault        (fault),
        .vehicle_count(vehicle_count),
        .long_vehicle (long_vehicle)
    );

    always #5 clk = ~clk;

    // cyc = number of rising edges seen so far
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
        n_checks++;
        if (obs !== exp_v) begin
            $display("FAIL %s edge=%0d got=%0d expected=%0d", tag, cyc, obs, exp_v);
        end else begin
            n_pass++;
        end
    endtask

    task automatic expect_at(input int c, input int kind, input int val, input string tag);
        exp_t e;
        e.cyc  = c;
        e.kind = kind;
        e.val  = val;
        e.tag  = tag;
        sb_q.push_back(e);
    endtask

    task automatic expect_span(input int c0, input int c1, input int kind, input int val,
                               input string tag);
        for (int c = c0; c <= c1; c++) expect_at(c, kind, val, tag);
    endtask

    function automatic logic [31:0] observe(input int kind);
        case (kind)
            K_SENSOR: observe = 32'(sensor);
            K_FAULT:  observe = 32'(fault);
            default:  observe = 32'(vehicle_count);
        endcase
    endfunction

    // Scoreboard monitor: compare every entry due on this edge.
    always @(negedge clk) begin
        for (int i = sb_q.size() - 1; i >= 0; i--) begin
            if (sb_q[i].cyc == cyc) begin
                check_val(sb_q[i].tag, observe(sb_q[i].kind), sb_q[i].val);
                sb_q.delete(i);
            end
        end
    end

    // Called at a falling edge. Holds loop_raw at v for the next n rising edges.
    task automatic drive(input logic v, input int n);
        loop_raw = v;
        repeat (n) @(negedge clk);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog edge=%0d got=timeout expected=finish", cyc);
        $fatal(1, "watchdog");
    end

    initial begin
        int s;

        // ---- reset held for 10 edges with loop_raw toggling ----
        expect_span(1, 10, K_SENSOR, 0, "rst_sensor");
        expect_span(1, 10, K_FAULT,  0, "rst_fault");
        expect_span(1, 10, K_COUNT,  0, "rst_count");
        for (int i = 0; i < 10; i++) begin
            loop_raw = ~loop_raw;
            @(negedge clk);
        end
        rst_n    = 1'b1;
        loop_raw = 1'b0;
        s = cyc;
        expect_span(s + 1, s + 10, K_SENSOR, 0, "post_rst_sensor");
        expect_at(s + 10, K_COUNT, 0, "post_rst_count");
        drive(1'b0, 10);

        // ---- glitch: 3-cycle pulse is rejected ----
        s = cyc;
        expect_span(s + 1, s + 23, K_SENSOR, 0, "glitch_sensor");
        expect_at(s + 23, K_COUNT, 0, "glitch_count");
        drive(1'b1, 3);
        drive(1'b0, 20);

        // ---- single vehicle: high 20 then low ----
        s = cyc;
        expect_span(s + 1, s + 6, K_SENSOR, 0, "single_rise_early");
        expect_span(s + 7, s + 34, K_SENSOR, 1, "single_present");
        expect_span(s + 35, s + 50, K_SENSOR, 0, "single_released");
        expect_at(s + 5, K_COUNT, exp_cnt, "single_count_before");
        exp_cnt++;
        expect_at(s + 6, K_COUNT, exp_cnt, "single_count_rise");
        expect_at(s + 50, K_COUNT, exp_cnt, "single_count_end");
        expect_at(s + 34, K_FAULT, 0, "single_fault");
        drive(1'b1, 20);
        drive(1'b0, 30);

        // ---- gap bridging: high 20, low 6, high 20 ----
        s = cyc;
        expect_at(s + 6, K_SENSOR, 0, "gap_rise_early");
        expect_span(s + 7, s + 60, K_SENSOR, 1, "gap_bridged");
        expect_span(s + 61, s + 86, K_SENSOR, 0, "gap_released");
        exp_cnt++;
        expect_span(s + 6, s + 31, K_COUNT, exp_cnt, "gap_count_first");
        exp_cnt++;
        expect_at(s + 32, K_COUNT, exp_cnt, "gap_count_second");
        expect_at(s + 86, K_COUNT, exp_cnt, "gap_count_end");
        drive(1'b1, 20);
        drive(1'b0, 6);
        drive(1'b1, 20);
        drive(1'b0, 40);

        // ---- stuck detector: high 200 cycles ----
        s = cyc;
        exp_cnt++;
        expect_at(s + 6, K_COUNT, exp_cnt, "stuck_count");
        expect_at(s + 6, K_SENSOR, 0, "stuck_rise_early");
        expect_span(s + 7, s + 206, K_SENSOR, 1, "stuck_sensor_high");
        expect_span(s + 7, s + 70, K_FAULT, 0, "stuck_fault_early");
        expect_span(s + 71, s + 206, K_FAULT, 1, "stuck_fault");
        expect_at(s + 207, K_SENSOR, 0, "stuck_release_sensor");
        expect_at(s + 207, K_FAULT, 0, "stuck_release_fault");
        expect_at(s + 230, K_SENSOR, 0, "stuck_idle");
        drive(1'b1, 200);
        drive(1'b0, 30);

        // ---- saturation: 300 clean pulses ----
        for (int k = 0; k < 300; k++) begin
            s = cyc;
            exp_cnt = (exp_cnt < 255) ? exp_cnt + 1 : 255;
            expect_at(s + 12, K_COUNT, exp_cnt, "sat_count");
            drive(1'b1, 6);
            drive(1'b0, 6);
        end

        // ---- count_clr on the same edge as a deb rise ----
        s = cyc;
        expect_at(s + 5, K_COUNT, 255, "clr_before");
        expect_at(s + 6, K_COUNT, 0, "clr_vs_rise");
        expect_at(s + 12, K_COUNT, 0, "clr_after");
        drive(1'b1, 5);
        count_clr = 1'b1;
        drive(1'b1, 1);
        count_clr = 1'b0;
        drive(1'b0, 6);
        exp_cnt = 0;

        // counting resumes after the clear
        s = cyc;
        exp_cnt++;
        expect_at(s + 6, K_COUNT, exp_cnt, "count_resume");
        expect_at(s + 32, K_SENSOR, 0, "resume_idle");
        drive(1'b1, 6);
        drive(1'b0, 26);

        // ---- reset while in HOLD ----
        s = cyc;
        exp_cnt++;
        expect_span(s + 7, s + 18, K_SENSOR, 1, "midhold_sensor_before");
        expect_at(s + 18, K_COUNT, exp_cnt, "midhold_count_before");
        expect_span(s + 19, s + 39, K_SENSOR, 0, "midhold_sensor_after");
        expect_at(s + 19, K_FAULT, 0, "midhold_fault_after");
        expect_span(s + 19, s + 39, K_COUNT, 0, "midhold_count_after");
        drive(1'b1, 10);
        drive(1'b0, 8);
        rst_n = 1'b0;
        drive(1'b0, 1);
        rst_n = 1'b1;
        drive(1'b0, 20);

        repeat (2) @(negedge clk);
        #1;
        check_val("sb_leftover", 32'(sb_q.size()), 0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
